cond_unit: RTL and testbench
============================

Name: cond_unit

Overview:
- Conditional-execution stage directly downstream of the instruction decoder in the single-cycle ARM datapath.
- Holds the architectural NZCV flag register.
- Evaluates the instruction's Cond field against the current flags, and gates the decoder's write/branch controls into committed PCSrc/RegWrite/MemWrite.
- Supplies the carry-in for ADC and updates flags from ALUFlags per FlagW.

Parameters:
- CNT_W, 32, width of the retired/skipped instruction counters (optional feature only).
- RESET_FLAGS, 4'b0000, NZCV value loaded on reset.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- InstrValid  input  1  current instruction is real; 0 = bubble, commits nothing.
- Cond  input  4  Instr[31:28] condition field.
- ALUFlags  input  4  {N,Z,C,V} produced by ALU for current instruction.
- FlagW  input  2  from decoder; [1] = write N,Z; [0] = write C,V.
- PCS  input  1  from decoder; instruction writes PC.
- RegW  input  1  from decoder; instruction writes register file.
- MemW  input  1  from decoder; instruction writes memory.
- NoWrite  input  1  from decoder; compare/test, suppress register write.
- CntClr  input  1  synchronous clear of perf counters.
- PCSrc  output  1  committed PC write.
- RegWrite  output  1  committed register write.
- MemWrite  output  1  committed memory write.
- CondEx  output  1  condition passed for the current instruction.
- Undef  output  1  Cond = 4'b1111 on a valid instruction.
- CarryIn  output  1  current registered C flag, fed to ALU for ADC.
- Flags  output  4  current registered {N,Z,C,V}.
- RetiredCnt  output  CNT_W  count of valid instructions with CondEx=1.
- SkippedCnt  output  CNT_W  count of valid instructions with CondEx=0.

Behaviour:
- Reset (reset=0, async):
  - Flags = RESET_FLAGS.
  - RetiredCnt = SkippedCnt = 0.
  - All combinational outputs follow from Flags with their inputs.
- Condition evaluation (combinational on registered Flags):
  - EQ 0000: Z. NE 0001: !Z. CS 0010: C. CC 0011: !C.
  - MI 0100: N. PL 0101: !N. VS 0110: V. VC 0111: !V.
  - HI 1000: C&!Z. LS 1001: !C|Z. GE 1010: N==V. LT 1011: N!=V.
  - GT 1100: !Z&(N==V). LE 1101: Z|(N!=V). AL 1110: 1.
  - 1111: CondEx=0, Undef=InstrValid.
- CondEx is forced to 0 when InstrValid=0.
- Gating:
  - PCSrc = PCS & CondEx.
  - RegWrite = RegW & CondEx & !NoWrite.
  - MemWrite = MemW & CondEx.
- Flag update at the rising edge when CondEx=1:
  - N,Z <= ALUFlags[3:2] if FlagW[1].
  - C,V <= ALUFlags[1:0] if FlagW[0].
  - Independent halves; otherwise hold.
- Flags and CarryIn reflect the pre-instruction value for the whole cycle; a new value is visible the cycle after the write.
- A failed-condition instruction never changes flags, including CMP with S and NoWrite=1.
- Bubble (InstrValid=0): no flag write, no counter change, all committed outputs 0.
- Reset asserted mid-cycle clears flags immediately, with no clock required.
- Deassertion is taken synchronously by the first clock edge after reset=1.

Optional Feature:
- Macro: COND_PERF_CNT_EN.
- Defined:
  - Each rising edge with InstrValid=1 increments RetiredCnt if CondEx else SkippedCnt, by exactly one.
  - Counters wrap modulo 2^CNT_W.
  - CntClr=1 zeroes both on the edge and takes priority over the same-cycle increment.
- Undefined:
  - Counters are not instantiated; RetiredCnt and SkippedCnt are tied 0.
  - CntClr is ignored.
  - The port list is unchanged.

Test Plan:
- Reset=0 with Flags previously 4'b1111 -> Flags=4'b0000 immediately, PCSrc=RegWrite=MemWrite=0 for Cond=0000 (EQ fails) regardless of PCS/RegW/MemW=1.
- SUBS-style: Cond=1110, FlagW=2'b11, ALUFlags=4'b0110, RegW=1 -> RegWrite=1 this cycle, Flags=4'b0110 next cycle, CarryIn=1 next cycle.
- CMP then BEQ: cycle 1 Cond=1110, NoWrite=1, RegW=1, FlagW=11, ALUFlags=0100 -> RegWrite=0. Cycle 2 Cond=0000, PCS=1 -> PCSrc=1.
- Failed condition: Flags=0000, Cond=0000, FlagW=11, ALUFlags=1111, MemW=1 -> MemWrite=0, CondEx=0, Flags still 0000 next cycle.
- Sweep all 16 Cond values across all 16 Flags values -> CondEx matches table. Cond=1111 with InstrValid=1 -> Undef=1, CondEx=0. InstrValid=0 -> all gated outputs 0, flags unchanged.
- COND_PERF_CNT_EN, CNT_W=4: 15 passing + 1 failing instruction -> RetiredCnt=15, SkippedCnt=1. One more pass -> RetiredCnt=0 (wrap). CntClr with a valid pass on the same edge -> both 0.

Source files
------------

// File: rtl/cond_unit.sv
// Conditional-execution stage: NZCV flag register, Cond evaluation and write gating.
// Optional perf counters (retired/skipped) are built only when COND_PERF_CNT_EN is defined.
module cond_unit #(
   parameter int         CNT_W       = 32,
   parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             InstrValid,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             NoWrite,
   input  logic             CntClr,
   output logic             PCSrc,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             CondEx,
   output logic             Undef,
   output logic             CarryIn,
   output logic [3:0]       Flags,
   output logic [CNT_W-1:0] RetiredCnt,
   output logic [CNT_W-1:0] SkippedCnt
);

   logic [3:0] flags_q;
   logic       n, z, c, v;
   logic       pass;

   assign {n, z, c, v} = flags_q;

   always_comb begin
      pass = 1'b0;
      case (Cond)
         4'b0000: pass = z;
         4'b0001: pass = ~z;
         4'b0010: pass = c;
         4'b0011: pass = ~c;
         4'b0100: pass = n;
         4'b0101: pass = ~n;
         4'b0110: pass = v;
         4'b0111: pass = ~v;
         4'b1000: pass = c & ~z;
         4'b1001: pass = ~c | z;
         4'b1010: pass = (n == v);
         4'b1011: pass = (n != v);
         4'b1100: pass = ~z & (n == v);
         4'b1101: pass = z | (n != v);
         4'b1110: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

   assign CondEx   = InstrValid & pass;
   assign Undef    = InstrValid & (Cond == 4'b1111);
   assign PCSrc    = PCS & CondEx;
   assign RegWrite = RegW & CondEx & ~NoWrite;
   assign MemWrite = MemW & CondEx;
   assign Flags    = flags_q;
   assign CarryIn  = flags_q[1];

   // NZ and CV halves update independently; a failed condition holds both.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flags_q <= RESET_FLAGS;
      end else if (CondEx) begin
         if (FlagW[1]) flags_q[3:2] <= ALUFlags[3:2];
         if (FlagW[0]) flags_q[1:0] <= ALUFlags[1:0];
      end
   end

`ifdef COND_PERF_CNT_EN
   logic [CNT_W-1:0] ret_q, skp_q;

   // Clear wins over the increment on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ret_q <= '0;
         skp_q <= '0;
      end else if (CntClr) begin
         ret_q <= '0;
         skp_q <= '0;
      end else if (InstrValid) begin
         if (CondEx) ret_q <= ret_q + CNT_W'(1);
         else        skp_q <= skp_q + CNT_W'(1);
      end
   end

   assign RetiredCnt = ret_q;
   assign SkippedCnt = skp_q;
`else
   logic unused_cntclr;
   assign unused_cntclr = CntClr;
   assign RetiredCnt    = '0;
   assign SkippedCnt    = '0;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: expected outputs are queued at drive time and
// compared at the following falling edge against an independent flag/counter model.
module tb_cond_unit;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          InstrValid, PCS, RegW, MemW, NoWrite, CntClr;
   logic [3:0]    Cond, ALUFlags;
   logic [1:0]    FlagW;
   logic          PCSrc, RegWrite, MemWrite, CondEx, Undef, CarryIn;
   logic [3:0]    Flags;
   logic [CW-1:0] RetiredCnt, SkippedCnt;

   always #5 clk = ~clk;

   cond_unit #(.CNT_W(CW), .RESET_FLAGS(4'b0000)) dut (
      .clk(clk), .reset(reset), .InstrValid(InstrValid), .Cond(Cond),
      .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
      .NoWrite(NoWrite), .CntClr(CntClr), .PCSrc(PCSrc), .RegWrite(RegWrite),
      .MemWrite(MemWrite), .CondEx(CondEx), .Undef(Undef), .CarryIn(CarryIn),
      .Flags(Flags), .RetiredCnt(RetiredCnt), .SkippedCnt(SkippedCnt)
   );

   typedef struct packed {
      logic          pcsrc, regwrite, memwrite, condex, undef, carryin;
      logic [3:0]    flags;
      logic [CW-1:0] ret, skp;
   } exp_t;

   exp_t          sb[$];
   int            checks = 0;
   int            errors = 0;
   logic [3:0]    mflags = 4'b0000;
   logic [CW-1:0] mret = '0, mskp = '0;

`ifdef COND_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   // ARM-style: evaluate the even condition, invert for odd codes; 1111 never passes.
   function automatic logic cond_ref(input logic [3:0] cc, input logic [3:0] f);
      logic nn, zz, cy, vv, base;
      {nn, zz, cy, vv} = f;
      case (cc[3:1])
         3'd0: base = zz;
         3'd1: base = cy;
         3'd2: base = nn;
         3'd3: base = vv;
         3'd4: base = cy & !zz;
         3'd5: base = (nn == vv);
         3'd6: base = !zz & (nn == vv);
         default: base = 1'b1;
      endcase
      if (cc == 4'b1111) return 1'b0;
      return base ^ cc[0];
   endfunction

   // Called just after a rising edge; returns just after the next one.
   task automatic issue(input logic v, input logic [3:0] cc, input logic [3:0] af,
                        input logic [1:0] fw, input logic pcs, input logic rw,
                        input logic mw, input logic nw, input logic clr);
      exp_t e, got;
      logic ce;
      InstrValid = v; Cond = cc; ALUFlags = af; FlagW = fw;
      PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw; CntClr = clr;
      ce          = v & cond_ref(cc, mflags);
      e.condex    = ce;
      e.undef     = v & (cc == 4'b1111);
      e.pcsrc     = pcs & ce;
      e.regwrite  = rw & ce & !nw;
      e.memwrite  = mw & ce;
      e.carryin   = mflags[1];
      e.flags     = mflags;
      e.ret       = PERF ? mret : '0;
      e.skp       = PERF ? mskp : '0;
      sb.push_back(e);
      @(negedge clk);
      got = sb.pop_front();
      chk("condex",   {31'd0, CondEx},   {31'd0, got.condex});
      chk("undef",    {31'd0, Undef},    {31'd0, got.undef});
      chk("pcsrc",    {31'd0, PCSrc},    {31'd0, got.pcsrc});
      chk("regwrite", {31'd0, RegWrite}, {31'd0, got.regwrite});
      chk("memwrite", {31'd0, MemWrite}, {31'd0, got.memwrite});
      chk("carryin",  {31'd0, CarryIn},  {31'd0, got.carryin});
      chk("flags",    {28'd0, Flags},    {28'd0, got.flags});
      chk("retired",  {28'd0, RetiredCnt}, {28'd0, got.ret});
      chk("skipped",  {28'd0, SkippedCnt}, {28'd0, got.skp});
      @(posedge clk);
      if (ce) begin
         if (fw[1]) mflags[3:2] = af[3:2];
         if (fw[0]) mflags[1:0] = af[1:0];
      end
      if (clr) begin
         mret = '0; mskp = '0;
      end else if (v) begin
         if (ce) mret = mret + 1'b1;
         else    mskp = mskp + 1'b1;
      end
      #1;
   endtask

   initial begin
      reset = 1'b0; InstrValid = 1'b0; Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00;
      PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0; CntClr = 1'b0;
      #3;
      chk("rst_flags",   {28'd0, Flags},      32'd0);
      chk("rst_retired", {28'd0, RetiredCnt}, 32'd0);
      chk("rst_skipped", {28'd0, SkippedCnt}, 32'd0);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;

      // SUBS, then observe flags/carry via the next instruction
      issue(1, 4'hE, 4'b0110, 2'b11, 0, 1, 0, 0, 0);
      // CMP (NoWrite) then BEQ
      issue(1, 4'hE, 4'b0100, 2'b11, 0, 1, 0, 1, 0);
      issue(1, 4'h0, 4'b0000, 2'b00, 1, 0, 0, 0, 0);
      // Independent halves: only CV written
      issue(1, 4'hE, 4'b1011, 2'b01, 0, 0, 0, 0, 0);
      // Failed condition never writes flags
      issue(1, 4'hE, 4'b0000, 2'b11, 0, 0, 0, 0, 0);
      issue(1, 4'h0, 4'b1111, 2'b11, 0, 0, 1, 0, 0);
      // Bubble: nothing commits
      issue(0, 4'hE, 4'b1111, 2'b11, 1, 1, 1, 0, 0);
      issue(1, 4'hF, 4'b1111, 2'b11, 1, 1, 1, 0, 0);

      // Full Cond x Flags sweep
      for (int f = 0; f < 16; f++) begin
         issue(1, 4'hE, 4'(f), 2'b11, 0, 0, 0, 0, 0);
         for (int cc = 0; cc < 16; cc++)
            issue(1, 4'(cc), 4'(15 - cc), 2'b00, 1, 1, 1, 0, 0);
      end

      // Async reset mid-cycle with flags at 1111
      issue(1, 4'hE, 4'b1111, 2'b11, 0, 0, 0, 0, 0);
      #2;
      InstrValid = 1'b1; Cond = 4'h0; PCS = 1'b1; RegW = 1'b1; MemW = 1'b1;
      FlagW = 2'b00; NoWrite = 1'b0; CntClr = 1'b0;
      #1;
      chk("pre_rst_flags", {28'd0, Flags}, 32'hF);
      reset = 1'b0;
      #1;
      mflags = 4'b0000; mret = '0; mskp = '0;
      chk("async_flags",  {28'd0, Flags},   32'd0);
      chk("async_pcsrc",  {31'd0, PCSrc},   32'd0);
      chk("async_regw",   {31'd0, RegWrite}, 32'd0);
      chk("async_memw",   {31'd0, MemWrite}, 32'd0);
      chk("async_ret",    {28'd0, RetiredCnt}, 32'd0);
      @(negedge clk); reset = 1'b1; InstrValid = 1'b0;
      @(posedge clk); #1;

      // Counters: 15 pass + 1 fail, wrap, then clear beats increment
      for (int i = 0; i < 15; i++) issue(1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 0);
      issue(1, 4'h0, 4'h0, 2'b00, 0, 1, 0, 0, 0);
      issue(1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 0);
      issue(1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 1);
      issue(0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
